// File: rtl/serial_arbiter_if.sv
// Stream bundle for serial_arbiter: two transmit requesters (CPU, debug),
// two receive consumers, and the byte link to/from the serial interface.
// The slave modport is the arbiter's view and the master modport is the
// surrounding system's view.
interface serial_arbiter_if;
  logic [7:0] c_wdata;
  logic       c_wvalid;
  logic       c_wready;
  logic [7:0] d_wdata;
  logic       d_wvalid;
  logic       d_wready;
  logic [7:0] c_rdata;
  logic       c_rvalid;
  logic       c_rready;
  logic [7:0] d_rdata;
  logic       d_rvalid;
  logic       d_rready;
  logic [7:0] s_odata;
  logic       s_ovalid;
  logic       s_oready;
  logic [7:0] s_idata;
  logic       s_ivalid;
  logic       s_iready;

  modport slave (
    input  c_wdata, c_wvalid, d_wdata, d_wvalid,
    input  c_rready, d_rready, s_oready, s_idata, s_ivalid,
    output c_wready, d_wready, c_rdata, c_rvalid, d_rdata, d_rvalid,
    output s_odata, s_ovalid, s_iready
  );

  modport master (
    output c_wdata, c_wvalid, d_wdata, d_wvalid,
    output c_rready, d_rready, s_oready, s_idata, s_ivalid,
    input  c_wready, d_wready, c_rdata, c_rvalid, d_rdata, d_rvalid,
    input  s_odata, s_ovalid, s_iready
  );
endinterface

// File: rtl/serial_arbiter.sv
// serial_arbiter: merges CPU and debug transmit streams onto one serial byte
// stream with fair alternation on contention, and routes received bytes to
// the CPU or debug consumer.
// Optional feature macro: SERIAL_ARB_ESCAPE_EN -- in-band escape commands
// (ESC_BYTE followed by 00/01) select the receive owner. Without it every
// received byte goes to the CPU and rx_owner is tied to 0.
module serial_arbiter #(
  parameter logic [7:0] ESC_BYTE = 8'h1B
) (
  input  logic        clk,
  input  logic        nrst,
  serial_arbiter_if.slave bus,
  output logic        rx_owner
);

  // ---------------- transmit ----------------
  logic       tx_full;
  logic [7:0] tx_data;
  logic       last_grant;   // 0 CPU, 1 debug; reset to 1 so CPU wins first tie
  logic       tx_load_ok;
  logic       grant_c;
  logic       grant_d;
  logic       tx_load;

  // Alternating grant: on contention the requester not served last wins.
  always_comb begin
    tx_load_ok = !tx_full | bus.s_oready;
    grant_c    = bus.c_wvalid & (!bus.d_wvalid | last_grant);
    grant_d    = bus.d_wvalid & (!bus.c_wvalid | !last_grant);
    tx_load    = tx_load_ok & (grant_c | grant_d);
  end

  assign bus.c_wready = tx_load_ok & grant_c;
  assign bus.d_wready = tx_load_ok & grant_d;
  assign bus.s_ovalid = tx_full;
  assign bus.s_odata  = tx_data;

  // Single output register; a drain and a reload can share one edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_full    <= 1'b0;
      tx_data    <= 8'h00;
      last_grant <= 1'b1;
    end else if (tx_load) begin
      tx_full    <= 1'b1;
      tx_data    <= grant_d ? bus.d_wdata : bus.c_wdata;
      last_grant <= grant_d;
    end else if (bus.s_oready) begin
      tx_full    <= 1'b0;
    end
  end

  // ---------------- receive ----------------
  logic       rx_full;
  logic [7:0] rx_data;
  logic       rx_dest;      // destination latched with the byte
  logic       dest_ready;
  logic       rx_accept;
  logic       rx_drain;
  logic       rx_store;     // accepted byte is payload, not a command

  // Accept whenever the holding register is empty or draining this edge.
  always_comb begin
    dest_ready = rx_dest ? bus.d_rready : bus.c_rready;
    rx_drain   = rx_full & dest_ready;
    rx_accept  = bus.s_ivalid & bus.s_iready;
  end

  assign bus.s_iready = !rx_full | dest_ready;
  assign bus.c_rdata  = rx_data;
  assign bus.d_rdata  = rx_data;
  assign bus.c_rvalid = rx_full & !rx_dest;

`ifdef SERIAL_ARB_ESCAPE_EN
  localparam logic [0:0] ROUTE = 1'b0;
  localparam logic [0:0] ESC   = 1'b1;

  logic [0:0] esc_state;
  logic [0:0] esc_state_nxt;
  logic       owner_nxt;

  // Escape decoder: ESC_BYTE opens a command, the next byte selects the
  // owner, is a literal ESC_BYTE, or is dropped.
  always_comb begin
    esc_state_nxt = esc_state;
    owner_nxt     = rx_owner;
    rx_store      = 1'b0;
    if (rx_accept) begin
      case (esc_state)
        ROUTE: begin
          if (bus.s_idata == ESC_BYTE) esc_state_nxt = ESC;
          else                         rx_store      = 1'b1;
        end
        default: begin
          esc_state_nxt = ROUTE;
          if (bus.s_idata == 8'h00)          owner_nxt = 1'b0;
          else if (bus.s_idata == 8'h01)     owner_nxt = 1'b1;
          else if (bus.s_idata == ESC_BYTE)  rx_store  = 1'b1;
        end
      endcase
    end
  end

  // Owner change only affects bytes accepted after the command byte.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      esc_state <= ROUTE;
      rx_owner  <= 1'b0;
    end else begin
      esc_state <= esc_state_nxt;
      rx_owner  <= owner_nxt;
    end
  end

  assign bus.d_rvalid = rx_full & rx_dest;
`else
  assign rx_store     = rx_accept;
  assign rx_owner     = 1'b0;
  assign bus.d_rvalid = 1'b0;
`endif

  // Receive holding register; load wins over drain so rx_full stays set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
      rx_dest <= 1'b0;
    end else if (rx_store) begin
      rx_full <= 1'b1;
      rx_data <= bus.s_idata;
      rx_dest <= rx_owner;
    end else if (rx_drain) begin
      rx_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// Scoreboard bench for serial_arbiter: stimulus pushes expected bytes into
// per-stream queues, a negedge monitor pops them on every handshake.
module tb_serial_arbiter;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic rx_owner;
  logic no_dw = 1'b0;

  serial_arbiter_if bus();

  serial_arbiter #(.ESC_BYTE(8'h1B)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .bus     (bus),
    .rx_owner(rx_owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_c[$];
  logic [7:0] exp_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no output", name, act);
  endtask

  // Monitor: every handshake on an output stream is checked against its queue.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.s_ovalid && bus.s_oready) begin
        if (exp_tx.size() == 0) unexpected("s_odata", bus.s_odata);
        else chk("s_odata", bus.s_odata, exp_tx.pop_front());
      end
      if (bus.c_rvalid && bus.c_rready) begin
        if (exp_c.size() == 0) unexpected("c_rdata", bus.c_rdata);
        else chk("c_rdata", bus.c_rdata, exp_c.pop_front());
      end
      if (bus.d_rvalid && bus.d_rready) begin
        if (exp_d.size() == 0) unexpected("d_rdata", bus.d_rdata);
        else chk("d_rdata", bus.d_rdata, exp_d.pop_front());
      end
      if (bus.c_wready || bus.d_wready)
        chk("wready_excl", {31'd0, bus.c_wready & bus.d_wready}, 0);
      if (no_dw && bus.c_wvalid)
        chk("d_wready_idle", {31'd0, bus.d_wready}, 0);
    end
  end

  // All drivers are entered at posedge+1 and return at posedge+1.
  task automatic send_c(input logic [7:0] b);
    int n = 0;
    bus.c_wdata  = b;
    bus.c_wvalid = 1'b1;
    @(negedge clk);
    while (!bus.c_wready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) unexpected("c_write_timeout", b);
    @(posedge clk); #1;
    bus.c_wvalid = 1'b0;
  endtask

  task automatic send_d(input logic [7:0] b);
    int n = 0;
    bus.d_wdata  = b;
    bus.d_wvalid = 1'b1;
    @(negedge clk);
    while (!bus.d_wready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) unexpected("d_write_timeout", b);
    @(posedge clk); #1;
    bus.d_wvalid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] b);
    int n = 0;
    bus.s_idata  = b;
    bus.s_ivalid = 1'b1;
    @(negedge clk);
    while (!bus.s_iready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) unexpected("s_in_timeout", b);
    @(posedge clk); #1;
    bus.s_ivalid = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_s_ovalid", {31'd0, bus.s_ovalid}, 0);
    chk("rst_c_rvalid", {31'd0, bus.c_rvalid}, 0);
    chk("rst_d_rvalid", {31'd0, bus.d_rvalid}, 0);
    chk("rst_rx_owner", {31'd0, rx_owner}, 0);
    chk("rst_s_odata", {24'd0, bus.s_odata}, 0);
    chk("rst_s_iready", {31'd0, bus.s_iready}, 1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.c_wdata = 8'h00; bus.c_wvalid = 1'b0;
    bus.d_wdata = 8'h00; bus.d_wvalid = 1'b0;
    bus.c_rready = 1'b0; bus.d_rready = 1'b0;
    bus.s_oready = 1'b0;
    bus.s_idata = 8'h00; bus.s_ivalid = 1'b0;
    #1;
    do_reset();

    // CPU alone: 11 then 22, debug never granted, one-cycle latency.
    bus.s_oready = 1'b1;
    no_dw = 1'b1;
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    send_c(8'h11);
    chk("tx_latency_valid", {31'd0, bus.s_ovalid}, 1);
    chk("tx_latency_data", {24'd0, bus.s_odata}, 32'h11);
    send_c(8'h22);
    no_dw = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Both requesters from reset: CPU wins first tie, then strict alternation.
    do_reset();
    bus.s_oready = 1'b1;
    exp_tx.push_back(8'hA0);
    exp_tx.push_back(8'hB0);
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'hB1);
    fork
      begin send_c(8'hA0); send_c(8'hA1); end
      begin send_d(8'hB0); send_d(8'hB1); end
    join
    repeat (3) @(posedge clk); #1;

    // Back-pressure: held byte stable, then drain with same-cycle reload.
    bus.s_oready = 1'b0;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h6B);
    fork
      begin send_c(8'h5A); send_c(8'h6B); end
    join_none
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_ovalid", {31'd0, bus.s_ovalid}, 1);
      chk("bp_s_odata", {24'd0, bus.s_odata}, 32'h5A);
      chk("bp_c_wready", {31'd0, bus.c_wready}, 0);
      chk("bp_d_wready", {31'd0, bus.d_wready}, 0);
    end
    @(posedge clk); #1;
    bus.s_oready = 1'b1;
    @(negedge clk);
    chk("bp_reload", {31'd0, bus.c_wready}, 1);
    repeat (4) @(posedge clk); #1;

    // Receive routing.
    bus.c_rready = 1'b1;
    bus.d_rready = 1'b1;
`ifdef SERIAL_ARB_ESCAPE_EN
    exp_c.push_back(8'h33);
    exp_d.push_back(8'h44);
    exp_d.push_back(8'h1B);
    exp_c.push_back(8'h55);
    send_s(8'h33); send_s(8'h1B); send_s(8'h01); send_s(8'h44);
    send_s(8'h1B); send_s(8'h1B); send_s(8'h1B); send_s(8'h00);
    send_s(8'h55);
`else
    exp_c.push_back(8'h1B);
    exp_c.push_back(8'h01);
    send_s(8'h1B);
    chk("rx_latency", {31'd0, bus.c_rvalid}, 1);
    send_s(8'h01);
`endif
    repeat (3) @(posedge clk); #1;
    chk("rx_owner_end", {31'd0, rx_owner}, 0);

    // Reset with bytes held in both directions: nothing may emerge.
    bus.s_oready = 1'b0;
    bus.c_rready = 1'b0;
    bus.d_rready = 1'b0;
    send_c(8'h77);
    send_s(8'h88);
    chk("pre_rst_s_ovalid", {31'd0, bus.s_ovalid}, 1);
    chk("pre_rst_c_rvalid", {31'd0, bus.c_rvalid}, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_s_ovalid", {31'd0, bus.s_ovalid}, 0);
    chk("async_c_rvalid", {31'd0, bus.c_rvalid}, 0);
    chk("async_d_rvalid", {31'd0, bus.d_rvalid}, 0);
    @(negedge clk);
    nrst = 1'b1;
    bus.s_oready = 1'b1;
    bus.c_rready = 1'b1;
    bus.d_rready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_s_ovalid", {31'd0, bus.s_ovalid}, 0);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("c_queue_empty", exp_c.size(), 0);
    chk("d_queue_empty", exp_d.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
